// File: rtl/uart_tx_arbiter_if.sv
// Byte-source and uart_tx side signals of the shared transmit channel.
// The master modport is the arbiter; the slave modport is the sources/uart_tx side.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   src_req;
    logic [8*NUM_REQ-1:0] src_data;
    logic [NUM_REQ-1:0]   src_ready;
    logic                 tx_req;
    logic [7:0]           tx_data;
    logic                 tx_ready;
    logic                 hold;
    logic [2:0]           grant_id;
    logic                 busy;

    modport master (
        input  src_req, src_data, tx_ready, hold,
        output src_ready, tx_req, tx_data, grant_id, busy
    );

    modport slave (
        output src_req, src_data, tx_ready, hold,
        input  src_ready, tx_req, tx_data, grant_id, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx byte channel between NUM_REQ sources.
// The owner keeps the channel until EOM_CHAR, MAX_BURST bytes, or IDLE_TIMEOUT idle cycles.
//
// state    | meaning
// ST_IDLE  | no owner; pick the next requester at or after the rr pointer
// ST_OWN   | grant_q owns the channel; its bytes pass straight through to uart_tx
module uart_tx_arbiter #(
    parameter int         NUM_REQ      = 2,
    parameter logic [7:0] EOM_CHAR     = 8'h0A,
    parameter int         MAX_BURST    = 64,
    parameter int         IDLE_TIMEOUT = 1024
) (
    input logic               clk,
    input logic               reset,
    uart_tx_arbiter_if.master bus
);
    localparam int TW = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic {
        ST_IDLE,
        ST_OWN
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    rr_q, rr_d;
    logic [2:0]    grant_q, grant_d;
    logic [7:0]    burst_q, burst_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic          owner_req;
    logic [7:0]    owner_data;
    logic          found;
    logic [2:0]    winner;
    logic          xfer;
    logic          release_now;
    int            idx;

    always_comb begin
        owner_req  = 1'b0;
        owner_data = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == 3'(i)) begin
                owner_req  = bus.src_req[i];
                owner_data = bus.src_data[8*i +: 8];
            end
        end
    end

    // Rotating priority search: first requester at or after rr_q, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = rr_q;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && idx == j && bus.src_req[j]) begin
                    found  = 1'b1;
                    winner = 3'(j);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rr_q    <= 3'd0;
            grant_q <= 3'd0;
            burst_q <= 8'd0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            burst_q <= burst_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        grant_d       = grant_q;
        burst_d       = burst_q;
        tmo_d         = tmo_q;
        xfer          = 1'b0;
        release_now   = 1'b0;
        bus.tx_req    = 1'b0;
        bus.tx_data   = 8'h00;
        bus.src_ready = '0;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d = ST_OWN;
                    grant_d = winner;
                    burst_d = 8'd0;
                    tmo_d   = '0;
                end
            end
            ST_OWN: begin
                bus.tx_req  = owner_req & ~bus.hold;
                bus.tx_data = owner_data;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (grant_q == 3'(i)) begin
                        bus.src_ready[i] = bus.tx_ready & ~bus.hold;
                    end
                end
                xfer = owner_req & ~bus.hold & bus.tx_ready;

                if (xfer) begin
                    burst_d = burst_q + 8'd1;
                end
                // Idle count only advances when the owner is silent and not paused.
                if (owner_req) begin
                    tmo_d = '0;
                end else if (!bus.hold) begin
                    tmo_d = tmo_q + TW'(1);
                end

                release_now = (xfer && (owner_data == EOM_CHAR ||
                                        burst_q == 8'(MAX_BURST - 1))) ||
                              (!owner_req && !bus.hold &&
                               tmo_q == TW'(IDLE_TIMEOUT - 1));

                if (release_now) begin
                    state_d = ST_IDLE;
                    rr_d    = (grant_q == 3'(NUM_REQ - 1)) ? 3'd0 : grant_q + 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.busy     = (state_q == ST_OWN);
    assign bus.grant_id = (state_q == ST_OWN) ? grant_q : 3'd0;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: two sources, MAX_BURST=4, IDLE_TIMEOUT=8.
// Inputs change on the falling edge; transfers are judged just before the rising edge.
module tb_uart_tx_arbiter;
    logic clk;
    logic reset;

    uart_tx_arbiter_if #(.NUM_REQ(2)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ(2),
        .EOM_CHAR(8'h0A),
        .MAX_BURST(4),
        .IDLE_TIMEOUT(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.master)
    );

    int         n_run;
    int         n_fail;
    logic [7:0] msg [2][32];
    int         len [2];
    int         ptr [2];
    logic [7:0] txq [$];
    logic       s_busy;
    logic       s_txreq;
    logic [2:0] s_grant;
    logic [1:0] s_ready;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_seq(input string tag, input logic [7:0] exp[$]);
        chk({tag, "_len"}, txq.size(), exp.size());
        for (int i = 0; i < exp.size() && i < txq.size(); i++) begin
            chk($sformatf("%s_b%0d", tag, i), {24'h0, txq[i]}, {24'h0, exp[i]});
        end
    endtask

    task automatic clr_src();
        for (int i = 0; i < 2; i++) begin
            len[i] = 0;
            ptr[i] = 0;
        end
    endtask

    task automatic push(input int s, input logic [7:0] b);
        msg[s][len[s]] = b;
        len[s]++;
    endtask

    task automatic drive();
        for (int i = 0; i < 2; i++) begin
            if (ptr[i] < len[i]) begin
                bus.src_req[i]        = 1'b1;
                bus.src_data[8*i +: 8] = msg[i][ptr[i]];
            end else begin
                bus.src_req[i]        = 1'b0;
                bus.src_data[8*i +: 8] = 8'h00;
            end
        end
    endtask

    task automatic sample();
        s_busy  = bus.busy;
        s_grant = bus.grant_id;
        s_txreq = bus.tx_req;
        s_ready = bus.src_ready;
        if (bus.tx_req && bus.tx_ready) begin
            txq.push_back(bus.tx_data);
        end
        for (int i = 0; i < 2; i++) begin
            if (bus.src_req[i] && bus.src_ready[i]) begin
                ptr[i]++;
            end
        end
    endtask

    task automatic tick();
        drive();
        #1;
        sample();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clr_src();
        drive();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        n_run        = 0;
        n_fail       = 0;
        reset        = 1'b1;
        bus.src_req  = '0;
        bus.src_data = '0;
        bus.tx_ready = 1'b1;
        bus.hold     = 1'b0;
        clr_src();

        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_tx_req", bus.tx_req, 0);
        chk("rst_tx_data", bus.tx_data, 0);
        chk("rst_src_ready", bus.src_ready, 0);
        chk("rst_grant", bus.grant_id, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Single source, "HI\n"
        txq.delete();
        push(0, 8'h48); push(0, 8'h49); push(0, 8'h0A);
        tick();
        chk("t1_idle_busy", s_busy, 0);
        chk("t1_idle_txreq", s_txreq, 0);
        tick();
        chk("t1_busy", s_busy, 1);
        chk("t1_grant", s_grant, 0);
        ticks(2);
        tick();
        chk("t1_release", s_busy, 0);
        chk_seq("t1", '{8'h48, 8'h49, 8'h0A});

        // Two sources from reset, no interleaving
        do_reset();
        txq.delete();
        push(0, 8'h41); push(0, 8'h42); push(0, 8'h0A);
        push(1, 8'h43); push(1, 8'h44); push(1, 8'h0A);
        ticks(9);
        chk_seq("t2a", '{8'h41, 8'h42, 8'h0A, 8'h43, 8'h44, 8'h0A});

        // Source 0 alone moves rr to 1, then both: source 1 first, source 0 second
        txq.delete();
        clr_src();
        push(0, 8'h5A); push(0, 8'h0A);
        ticks(4);
        clr_src();
        push(0, 8'h31); push(0, 8'h0A);
        push(1, 8'h32); push(1, 8'h0A);
        tick();
        tick();
        chk("t2_grant_first", s_grant, 1);
        ticks(5);
        chk_seq("t2b", '{8'h5A, 8'h0A, 8'h32, 8'h0A, 8'h31, 8'h0A});

        // MAX_BURST=4: source 1 streams, source 0 waits
        do_reset();
        txq.delete();
        for (int b = 0; b < 10; b++) begin
            push(1, 8'h10 + 8'(b));
        end
        tick();
        push(0, 8'hA0); push(0, 8'h0A);
        ticks(4);
        tick();
        chk("t3_gap_busy", s_busy, 0);
        chk("t3_gap_ready", s_ready, 0);
        tick();
        chk("t3_grant0", s_grant, 0);
        ticks(24);
        chk("t3_end_busy", s_busy, 0);
        chk_seq("t3", '{8'h10, 8'h11, 8'h12, 8'h13, 8'hA0, 8'h0A,
                        8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19});

        // IDLE_TIMEOUT=8: one byte then silence, source 1 pending
        do_reset();
        txq.delete();
        push(0, 8'h55);
        ticks(2);
        push(1, 8'h66); push(1, 8'h0A);
        ticks(7);
        tick();
        chk("t4_before_tmo", s_busy, 1);
        chk("t4_ready_mask", s_ready, 2'b01);
        tick();
        chk("t4_tmo_release", s_busy, 0);
        tick();
        chk("t4_grant1", s_grant, 1);
        ticks(2);
        chk_seq("t4", '{8'h55, 8'h66, 8'h0A});

        // hold for 20 cycles mid-message
        do_reset();
        txq.delete();
        push(0, 8'h70); push(0, 8'h71); push(0, 8'h72); push(0, 8'h0A);
        ticks(3);
        bus.hold = 1'b1;
        tick();
        chk("t5_hold_txreq", s_txreq, 0);
        chk("t5_hold_ready", s_ready, 0);
        chk("t5_hold_busy", s_busy, 1);
        ticks(19);
        chk("t5_hold_end_busy", s_busy, 1);
        chk("t5_hold_end_txreq", s_txreq, 0);
        chk("t5_no_xfer", txq.size(), 2);
        bus.hold = 1'b0;
        ticks(3);
        chk("t5_release", s_busy, 0);
        chk_seq("t5", '{8'h70, 8'h71, 8'h72, 8'h0A});

        // Reset mid-message after rr was moved to 1
        do_reset();
        txq.delete();
        push(0, 8'hE0); push(0, 8'h0A);
        ticks(4);
        clr_src();
        push(1, 8'h90); push(1, 8'h91); push(1, 8'h92); push(1, 8'h0A);
        ticks(2);
        drive();
        #1;
        chk("t6_pre_txreq", bus.tx_req, 1);
        chk("t6_pre_txdata", bus.tx_data, 8'h91);
        reset = 1'b1;
        #1;
        chk("t6_rst_txreq", bus.tx_req, 0);
        chk("t6_rst_txdata", bus.tx_data, 0);
        chk("t6_rst_busy", bus.busy, 0);
        chk("t6_rst_ready", bus.src_ready, 0);
        chk("t6_rst_grant", bus.grant_id, 0);
        clr_src();
        txq.delete();
        push(0, 8'hA1); push(0, 8'h0A);
        push(1, 8'hB1); push(1, 8'h0A);
        drive();
        @(negedge clk);
        reset = 1'b0;
        ticks(2);
        chk("t6_lowest", s_grant, 0);
        ticks(6);
        chk_seq("t6", '{8'hA1, 8'h0A, 8'hB1, 8'h0A});

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
